trng_sample_ctrl: RTL and testbench
===================================

// Module: trng_sample_ctrl
// PURPOSE
//  Sequences entropy sampling for the TRNG. Gated by a programmable tick (clock-enable) scheduler, it
//  discards a warm-up window, shifts synchronised raw bits into words and hands each word to the
//  consumer over valid/ready. Sits between the ring-oscillator raw_bit source and the output/UART
//  path. Uses a clock enable on clk_in; no derived clocks.
// PARAMETERS
//  WORD_W        8        bits per output word (>=2)
//  DIV_W         22       width of tick divider register
//  DEFAULT_DIV   2083333  divider value loaded at reset (tick period = div_reg+1 cycles)
//  WARMUP_TICKS  16       ticks discarded after each IDLE->active transition (>=1)
//  REP_LIMIT     32       repetition-count limit, used only with TRNG_HEALTH_EN (>=2)
// PORTS
//  clk_in       in   1       system clock
//  reset        in   1       synchronous, active-high reset
//  enable       in   1       level; 1 = run sampling
//  div_load     in   1       pulse; load div_value into div_reg (accepted in IDLE only)
//  div_value    in   DIV_W   new divider value
//  raw_bit      in   1       asynchronous entropy bit
//  word_out     out  WORD_W  assembled random word, stable while word_valid=1
//  word_valid   out  1       word_out holds a fresh word
//  word_ready   in   1       consumer accepts word when word_valid & word_ready
//  busy         out  1       1 in any state other than IDLE
//  health_fail  out  1       sticky health-test failure (constant 0 without TRNG_HEALTH_EN)
// BEHAVIOUR
//  - Reset: state=IDLE, div_reg=DEFAULT_DIV, tick_cnt=0, shreg=0, bit_cnt=0, word_out=0,
//    word_valid=0, busy=0, health_fail=0, synchroniser flops=0.
//  - raw_bit passes a 2-flop synchroniser (raw_s); 2-cycle latency, no other filtering.
//  - Tick: tick_cnt runs 0..div_reg, wraps to 0; tick=1 for the one cycle where tick_cnt==div_reg.
//    div_reg=0 gives tick every cycle. tick_cnt is held at 0 in IDLE.
//    div_load outside IDLE is ignored. div_load in IDLE updates div_reg next cycle.
//  - FSM states: IDLE, WARMUP, SAMPLE, OUTPUT (+FAULT with macro).
//    IDLE  : enable=1 -> WARMUP, warm_cnt=0.
//    WARMUP: on tick warm_cnt++. On the tick where warm_cnt==WARMUP_TICKS-1 -> SAMPLE, bit_cnt=0.
//    SAMPLE: on tick shreg<={shreg[WORD_W-2:0],raw_s}, bit_cnt++. On the tick with
//            bit_cnt==WORD_W-1 -> OUTPUT. word_out gets the complete shifted word and
//            word_valid=1 from the next cycle.
//    OUTPUT: hold word_out/word_valid until word_valid&word_ready. Then word_valid=0 the next
//            cycle and go to SAMPLE if enable=1, else IDLE. Ticks in OUTPUT are not sampled.
//            tick_cnt keeps running.
//  - enable=0 in WARMUP/SAMPLE -> IDLE next cycle. Partial word and bit_cnt are discarded.
//    enable=0 in OUTPUT does not abort. The pending word is still delivered, then IDLE.
//  - word_ready while word_valid=0 has no effect. Back-to-back words are separated by
//    >=WORD_W ticks.
//  - reset mid-operation overrides everything. A pending word is lost and word_valid=0 next cycle.
// CONFIGURATION
//  Macro TRNG_HEALTH_EN:
//   defined: repetition-count test on each sampled bit in SAMPLE. rep_cnt increments when
//     raw_s equals the previous sampled bit and resets to 1 otherwise. When rep_cnt reaches
//     REP_LIMIT -> FAULT. health_fail=1 (sticky), word_valid=0, busy=1, no further words.
//     Only reset exits FAULT. A word already pending in OUTPUT is still delivered.
//   undefined: no rep_cnt, no FAULT state, health_fail tied to 0.
// STRUCTURE
//  - Package trng_pkg: state enum (IDLE, WARMUP, SAMPLE, OUTPUT, FAULT) and default widths and
//    constants (WORD_W, DIV_W, DEFAULT_DIV).
//  - Sub-module trng_tick_gen: div_reg, tick_cnt, load/hold logic. Outputs a 1-cycle tick.
//  - Top holds the synchroniser, FSM, shift register, handshake and health test.
// TESTING
//  1. Reset, then div_load=1 with div_value=3 in IDLE and enable=1 -> tick every 4 cycles. First
//     word_valid after (16+8)*4 cycles (+-sync latency). word_out = the bits driven, MSB first.
//  2. raw_bit pattern 1,0,1,1,0,0,1,0 per tick, div=0 -> word_out=8'hB2. word_ready=0 for 20
//     cycles -> word_out/word_valid stable. Ready pulse -> word_valid=0 next cycle.
//  3. Drop enable after 3 SAMPLE ticks -> IDLE next cycle, busy=0, no word. Re-enable ->
//     WARMUP repeats, and the next word contains only fresh bits.
//  4. div_load with value 7 while in SAMPLE -> ignored, tick period stays 4 cycles.
//     enable=0 while in OUTPUT -> word still delivered, then IDLE.
//  5. TRNG_HEALTH_EN, REP_LIMIT=32, raw_bit stuck at 0 -> health_fail=1 after the 32nd equal
//     sample and stays 1. No more word_valid until reset. Without the macro -> health_fail=0
//     and words 8'h00 keep flowing.
//  6. Assert reset while word_valid=1 -> word_valid=0, busy=0, div_reg=DEFAULT_DIV next cycle.

Source files
------------

// File: rtl/trng_pkg.sv
// Shared state encoding and default sizing for the TRNG sampling controller.
package trng_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WARMUP,
    ST_SAMPLE,
    ST_OUTPUT,
    ST_FAULT
  } state_e;

  localparam int WORD_W_DEF       = 8;
  localparam int DIV_W_DEF        = 22;
  localparam int DEFAULT_DIV_DEF  = 2083333;
  localparam int WARMUP_TICKS_DEF = 16;
  localparam int REP_LIMIT_DEF    = 32;

endpackage

// File: rtl/trng_tick_gen.sv
// Programmable tick scheduler: one-cycle tick every div_reg+1 cycles, counter parked at 0 while held.
module trng_tick_gen
  import trng_pkg::*;
#(
  parameter int DIV_W       = DIV_W_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             hold_i,
  input  logic             load_i,
  input  logic [DIV_W-1:0] value_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;

  // Divider is only writable while held, so the counter can never sit above a shrunken limit.
  always_comb begin
    div_d = div_q;
    cnt_d = cnt_q;
    if (hold_i) begin
      cnt_d = '0;
      if (load_i) div_d = value_i;
    end else if (cnt_q == div_q) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      div_q <= DIV_W'(DEFAULT_DIV);
      cnt_q <= '0;
    end else begin
      div_q <= div_d;
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = !hold_i && (cnt_q == div_q);

endmodule

// File: rtl/trng_sample_ctrl.sv
// TRNG sampling sequencer: synchroniser, warm-up/sample/output FSM, word handshake.
// Optional repetition-count health test enabled by defining TRNG_HEALTH_EN.
module trng_sample_ctrl
  import trng_pkg::*;
#(
  parameter int WORD_W       = WORD_W_DEF,
  parameter int DIV_W        = DIV_W_DEF,
  parameter int DEFAULT_DIV  = DEFAULT_DIV_DEF,
  parameter int WARMUP_TICKS = WARMUP_TICKS_DEF,
  parameter int REP_LIMIT    = REP_LIMIT_DEF
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              enable,
  input  logic              div_load,
  input  logic [DIV_W-1:0]  div_value,
  input  logic              raw_bit,
  output logic [WORD_W-1:0] word_out,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              busy,
  output logic              health_fail
);

  localparam int WARM_W = $clog2(WARMUP_TICKS + 1);
  localparam int BIT_W  = $clog2(WORD_W);

  if (WORD_W < 2 || WARMUP_TICKS < 1 || REP_LIMIT < 2) begin : g_param_check
    $error("trng_sample_ctrl: illegal parameter value");
  end

  state_e              state_q, state_d;
  logic [WARM_W-1:0]   warm_q, warm_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [WORD_W-2:0]   shreg_q, shreg_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic                valid_q, valid_d;
  logic                sync1_q, sync2_q;
  logic                raw_s;
  logic                tick;
  logic                sample_en;
  logic                rep_hit;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= raw_bit;
      sync2_q <= sync1_q;
    end
  end
  assign raw_s = sync2_q;

  trng_tick_gen #(
    .DIV_W       (DIV_W),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) u_tick (
    .clk_in  (clk_in),
    .reset   (reset),
    .hold_i  (state_q == ST_IDLE),
    .load_i  (div_load),
    .value_i (div_value),
    .tick_o  (tick)
  );

  assign sample_en = (state_q == ST_SAMPLE) && enable && tick;

`ifdef TRNG_HEALTH_EN
  localparam int REP_W = $clog2(REP_LIMIT + 1);
  logic [REP_W-1:0] rep_q, rep_nxt;
  logic             prev_q;

  // Run length carries across word boundaries; only reset clears it.
  assign rep_nxt = (raw_s == prev_q) ? rep_q + 1'b1 : REP_W'(1);
  assign rep_hit = (rep_nxt == REP_W'(REP_LIMIT));

  always_ff @(posedge clk_in) begin
    if (reset) begin
      rep_q  <= '0;
      prev_q <= 1'b0;
    end else if (sample_en) begin
      rep_q  <= rep_nxt;
      prev_q <= raw_s;
    end
  end

  assign health_fail = (state_q == ST_FAULT);
`else
  assign rep_hit     = 1'b0;
  assign health_fail = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    warm_d  = warm_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    word_d  = word_q;
    valid_d = valid_q;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_WARMUP;
          warm_d  = '0;
        end
      end
      ST_WARMUP: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (tick) begin
          if (warm_q == WARM_W'(WARMUP_TICKS - 1)) begin
            state_d = ST_SAMPLE;
            bit_d   = '0;
          end else begin
            warm_d = warm_q + 1'b1;
          end
        end
      end
      ST_SAMPLE: begin
        if (!enable) begin
          state_d = ST_IDLE;
          bit_d   = '0;
        end else if (sample_en) begin
          bit_d = bit_q + 1'b1;
          if (WORD_W > 2) shreg_d = {shreg_q[WORD_W-3:0], raw_s};
          else            shreg_d = raw_s;
          if (rep_hit) begin
            state_d = ST_FAULT;
          end else if (bit_q == BIT_W'(WORD_W - 1)) begin
            state_d = ST_OUTPUT;
            word_d  = {shreg_q, raw_s};
            valid_d = 1'b1;
            bit_d   = '0;
          end
        end
      end
      ST_OUTPUT: begin
        // Enable is only consulted after the pending word has been taken.
        if (valid_q && word_ready) begin
          valid_d = 1'b0;
          bit_d   = '0;
          state_d = enable ? ST_SAMPLE : ST_IDLE;
        end
      end
      ST_FAULT: begin
        valid_d = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q <= ST_IDLE;
      warm_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      warm_q  <= warm_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      word_q  <= word_d;
      valid_q <= valid_d;
    end
  end

  assign word_out   = word_q;
  assign word_valid = valid_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_trng_sample_ctrl.sv
// Directed bench for trng_sample_ctrl: vector table of divider/bit patterns plus hand-written corner sequences.
module tb_trng_sample_ctrl;

  localparam int WW   = 8;
  localparam int DW   = 22;
  localparam int DDIV = 2;
  localparam int WT   = 16;
  localparam int RL   = 32;

  logic          clk_in = 1'b0;
  logic          reset;
  logic          enable;
  logic          div_load;
  logic [DW-1:0] div_value;
  logic          raw_bit;
  logic [WW-1:0] word_out;
  logic          word_valid;
  logic          word_ready;
  logic          busy;
  logic          health_fail;

  int checks   = 0;
  int failures = 0;

  always #5 clk_in = ~clk_in;

  trng_sample_ctrl #(
    .WORD_W       (WW),
    .DIV_W        (DW),
    .DEFAULT_DIV  (DDIV),
    .WARMUP_TICKS (WT),
    .REP_LIMIT    (RL)
  ) dut (
    .clk_in      (clk_in),
    .reset       (reset),
    .enable      (enable),
    .div_load    (div_load),
    .div_value   (div_value),
    .raw_bit     (raw_bit),
    .word_out    (word_out),
    .word_valid  (word_valid),
    .word_ready  (word_ready),
    .busy        (busy),
    .health_fail (health_fail)
  );

  typedef struct {
    bit         do_load;
    int         div;
    logic [7:0] bits;
    logic [7:0] exp_word;
    int         exp_lat;
    int         hold;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Raise enable from IDLE and feed bits so bit j lands on sample tick j; lat = edges until word_valid.
  task automatic run_word(input int d, input logic [7:0] bits, input int glitch_n, output int lat);
    int n;
    lat    = -1;
    enable = 1'b1;
    step();
    n = 0;
    while (n < 3000 && lat < 0) begin
      for (int j = 1; j <= 8; j++)
        if (n == (WT + j) * (d + 1) - 3) raw_bit = bits[8-j];
      if (n == glitch_n) begin
        div_load  = 1'b1;
        div_value = 7;
      end else begin
        div_load = 1'b0;
      end
      step();
      n++;
      if (word_valid) lat = n;
    end
    div_load = 1'b0;
  endtask

  task automatic deliver(input string name);
    enable     = 1'b0;
    word_ready = 1'b1;
    step();
    word_ready = 1'b0;
    chk({name, "_valid_drop"}, word_valid, 0);
    chk({name, "_idle"}, busy, 0);
  endtask

  initial begin
    int  lat;
    int  nwords;
    bit  stable;
    bit  zero_ok;

    vecs[0] = '{0, 2, 8'h5A, 8'h5A, 72, 3};
    vecs[1] = '{1, 3, 8'hA5, 8'hA5, 96, 2};
    vecs[2] = '{1, 0, 8'hB2, 8'hB2, 24, 20};
    vecs[3] = '{1, 1, 8'h3C, 8'h3C, 48, 1};
    vecs[4] = '{1, 5, 8'h80, 8'h80, 144, 1};
    vecs[5] = '{1, 0, 8'h01, 8'h01, 24, 1};

    reset      = 1'b1;
    enable     = 1'b0;
    div_load   = 1'b0;
    div_value  = '0;
    raw_bit    = 1'b0;
    word_ready = 1'b0;
    step();
    step();
    chk("rst_valid", word_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_health", health_fail, 0);
    chk("rst_word", word_out, 0);
    reset = 1'b0;
    word_ready = 1'b1;
    step();
    word_ready = 1'b0;
    chk("idle_ready_noeffect", word_valid, 0);

    for (int i = 0; i < 6; i++) begin
      if (vecs[i].do_load) begin
        div_load  = 1'b1;
        div_value = DW'(vecs[i].div);
        step();
        div_load = 1'b0;
      end
      run_word(vecs[i].div, vecs[i].bits, -1, lat);
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
      chk($sformatf("vec%0d_word", i), word_out, vecs[i].exp_word);
      chk($sformatf("vec%0d_busy", i), busy, 1);
      enable = 1'b0;
      stable = 1'b1;
      for (int c = 0; c < vecs[i].hold; c++) begin
        step();
        if (!word_valid || word_out !== vecs[i].exp_word || !busy) stable = 1'b0;
      end
      chk($sformatf("vec%0d_hold_stable", i), stable, 1);
      deliver($sformatf("vec%0d", i));
    end

    // Abort after three sample ticks, then a clean restart.
    div_load  = 1'b1;
    div_value = 3;
    step();
    div_load = 1'b0;
    enable   = 1'b1;
    raw_bit  = 1'b1;
    for (int n = 0; n <= 19 * 4; n++) step();
    enable = 1'b0;
    step();
    chk("abort_busy", busy, 0);
    chk("abort_valid", word_valid, 0);
    run_word(3, 8'h69, -1, lat);
    chk("restart_latency", lat, 96);
    chk("restart_word", word_out, 8'h69);
    deliver("restart");

    // div_load during SAMPLE must not change the tick period.
    run_word(3, 8'hC3, 17 * 4 + 1, lat);
    chk("ignored_load_latency", lat, 96);
    chk("ignored_load_word", word_out, 8'hC3);
    deliver("ignored_load");

    // Reset while a word is pending; divider returns to its default.
    div_load  = 1'b1;
    div_value = 0;
    step();
    div_load = 1'b0;
    run_word(0, 8'hE7, -1, lat);
    chk("pre_reset_valid", word_valid, 1);
    reset = 1'b1;
    step();
    reset  = 1'b0;
    enable = 1'b0;
    chk("midrst_valid", word_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_word", word_out, 0);
    run_word(DDIV, 8'h96, -1, lat);
    chk("midrst_default_div_latency", lat, 72);
    chk("midrst_default_div_word", word_out, 8'h96);
    deliver("midrst");

    // Stuck-at-0 source with a consumer that is always ready.
    reset = 1'b1;
    step();
    reset     = 1'b0;
    div_load  = 1'b1;
    div_value = 0;
    step();
    div_load   = 1'b0;
    raw_bit    = 1'b0;
    word_ready = 1'b1;
    enable     = 1'b1;
    nwords     = 0;
    zero_ok    = 1'b1;
    for (int c = 0; c < 400; c++) begin
      step();
      if (word_valid) begin
        nwords++;
        if (word_out !== 8'h00) zero_ok = 1'b0;
      end
    end
    chk("stuck_words_zero", zero_ok, 1);
`ifdef TRNG_HEALTH_EN
    chk("stuck_word_count", nwords, 3);
    chk("stuck_health_fail", health_fail, 1);
    chk("stuck_fault_busy", busy, 1);
    enable = 1'b0;
    for (int c = 0; c < 5; c++) step();
    chk("stuck_health_sticky", health_fail, 1);
    chk("stuck_fault_no_valid", word_valid, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("fault_cleared_by_reset", health_fail, 0);
`else
    chk("stuck_word_count", nwords, 42);
    chk("stuck_health_fail", health_fail, 0);
    chk("stuck_busy", busy, 1);
`endif
    word_ready = 1'b0;
    enable     = 1'b0;
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
